// File: rtl/axi4_dma_master_if.sv
// AXI4 channel bundle shared by the DMA master and the slave it drives.
// Widths follow the instance parameters.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi4_dma_master.sv
// Block-copy DMA initiator: INCR read burst into a local buffer, then INCR write
// burst out, repeated until the requested word count has been moved.
module axi4_dma_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BURST  = 16,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  axi4_if.master                m
);
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int SIZE_LOG = $clog2(BYTES);
  localparam int IDX_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int BEAT_W   = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] src, dst;
  logic [15:0]           remaining;
  logic [BEAT_W-1:0]     beats, beats_calc, beat_idx;
  logic                  err_pend;
  logic [DATA_WIDTH-1:0] buffer [MAX_BURST];

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, last_beat;

  assign ar_hs     = m.arvalid && m.arready;
  assign r_hs      = m.rvalid  && m.rready;
  assign aw_hs     = m.awvalid && m.awready;
  assign w_hs      = m.wvalid  && m.wready;
  assign b_hs      = m.bvalid  && m.bready;
  assign last_beat = (beat_idx == beats - BEAT_W'(1));

  function automatic logic [16:0] to_boundary(input logic [ADDR_WIDTH-1:0] addr);
    logic [12:0] bytes_left;
    bytes_left = 13'd4096 - {1'b0, addr[11:0]};
    return {4'd0, bytes_left >> SIZE_LOG};
  endfunction

  // src/dst/remaining only change in WR_RESP, so this is stable for the whole AR phase.
  always_comb begin
    logic [16:0] lim;
    lim = {1'b0, remaining};
    if (17'(MAX_BURST) < lim) lim = 17'(MAX_BURST);
    if (to_boundary(src) < lim) lim = to_boundary(src);
    if (to_boundary(dst) < lim) lim = to_boundary(dst);
    beats_calc = lim[BEAT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (num_words == 16'd0) ? DONE : RD_ADDR;
      RD_ADDR: if (ar_hs) state_next = RD_DATA;
      RD_DATA: if (r_hs && last_beat) state_next = WR_ADDR;
      WR_ADDR: if (aw_hs) state_next = WR_DATA;
      WR_DATA: if (w_hs && last_beat) state_next = WR_RESP;
      WR_RESP: if (b_hs) begin
        if (remaining == 16'(beats) || err_pend || m.bresp != 2'b00) state_next = DONE;
        else                                                          state_next = RD_ADDR;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE) && (state != DONE);
    unique case (state)
      RD_ADDR: m.arvalid = 1'b1;
      RD_DATA: m.rready  = 1'b1;
      WR_ADDR: m.awvalid = 1'b1;
      WR_DATA: m.wvalid  = 1'b1;
      WR_RESP: m.bready  = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  assign m.arid    = AXI_ID;
  assign m.araddr  = src;
  assign m.arlen   = 8'(beats_calc - BEAT_W'(1));
  assign m.arsize  = 3'(SIZE_LOG);
  assign m.arburst = 2'b01;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arqos   = 4'd0;

  assign m.awid    = AXI_ID;
  assign m.awaddr  = dst;
  assign m.awlen   = 8'(beats - BEAT_W'(1));
  assign m.awsize  = 3'(SIZE_LOG);
  assign m.awburst = 2'b01;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awqos   = 4'd0;

  assign m.wdata   = buffer[beat_idx[IDX_W-1:0]];
  assign m.wstrb   = '1;
  assign m.wlast   = last_beat;

  always_ff @(posedge clk) begin
    if (state == RD_DATA && r_hs) buffer[beat_idx[IDX_W-1:0]] <= m.rdata;
  end

  // A failed read still runs its write burst; err_pend just steers WR_RESP to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_idx  <= '0;
      err_pend  <= 1'b0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          src       <= src_addr;
          dst       <= dst_addr;
          remaining <= num_words;
          beat_idx  <= '0;
          err_pend  <= 1'b0;
          error     <= 1'b0;
        end
        RD_ADDR: if (ar_hs) begin
          beats    <= beats_calc;
          beat_idx <= '0;
        end
        RD_DATA: if (r_hs) begin
          if (m.rresp != 2'b00 || m.rlast != last_beat) err_pend <= 1'b1;
          beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
        end
        WR_DATA: if (w_hs) beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
        WR_RESP: if (b_hs) begin
          if (m.bresp != 2'b00) err_pend <= 1'b1;
          remaining <= remaining - 16'(beats);
          src       <= src + (ADDR_WIDTH'(beats) << SIZE_LOG);
          dst       <= dst + (ADDR_WIDTH'(beats) << SIZE_LOG);
        end
        DONE: error <= err_pend;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_dma_master.sv
// Directed bench for axi4_dma_master: a behavioural AXI4 memory slave with optional
// stalls and read-error injection, protocol monitors, and a forward-copy reference model.
module tb_axi4_dma_master;
  localparam int AW = 32, DW = 64, IW = 8, MB = 16, MEM_WORDS = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [15:0]   num_words = '0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi4_dma_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB), .AXI_ID(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_words(num_words), .busy(busy), .done(done), .error(error), .m(bus)
  );

  int pass_checks = 0, total_checks = 0;
  logic stall_en = 1'b0, inject_err = 1'b0;

  logic [DW-1:0] mem [MEM_WORDS];
  logic [DW-1:0] ref_mem [MEM_WORDS];

  logic          rd_active, wr_active, b_pend;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_len, rd_beat, wr_len, wr_beat;
  int            ar_stall, r_stall, aw_stall, w_stall, b_stall;
  int            ar_count, aw_count, w_count, b_count;
  int            viol_stable, viol_wearly, viol_wbeat, valid_cycles;
  logic [AW-1:0] ar_addr_log [8], aw_addr_log [8];
  logic [7:0]    ar_len_log [8], aw_len_log [8];
  logic [12:0]   ar_attr_log;
  logic          ar_wait_prev, aw_wait_prev, w_wait_prev;
  logic [AW-1:0] ar_addr_prev, aw_addr_prev;
  logic [7:0]    ar_len_prev, aw_len_prev;
  logic [DW-1:0] w_data_prev;
  logic          w_last_prev;

  function automatic int stall_pick();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  function automatic int word_idx(input logic [AW-1:0] addr, input logic [7:0] beat);
    return int'(((addr >> 3) + {24'd0, beat}) & 32'(MEM_WORDS - 1));
  endfunction

  assign bus.rid = '0;
  assign bus.bid = '0;

  // Slave memory model; reset reloads the 0x1000+i pattern.
  always @(posedge clk) begin
    if (rst) begin
      bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rlast <= 1'b0; bus.rresp <= 2'b00;
      bus.rdata <= '0; bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0;
      bus.bresp <= 2'b00;
      rd_active <= 1'b0; wr_active <= 1'b0; b_pend <= 1'b0;
      rd_addr <= '0; wr_addr <= '0; rd_len <= '0; rd_beat <= '0; wr_len <= '0; wr_beat <= '0;
      ar_stall <= stall_pick(); r_stall <= 0; aw_stall <= stall_pick(); w_stall <= 0; b_stall <= 0;
      ar_count <= 0; aw_count <= 0; w_count <= 0; b_count <= 0;
      viol_stable <= 0; viol_wearly <= 0; viol_wbeat <= 0; valid_cycles <= 0;
      ar_wait_prev <= 1'b0; aw_wait_prev <= 1'b0; w_wait_prev <= 1'b0;
      ar_attr_log <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 64'h1000 + 64'(i);
    end else begin
      if (ar_wait_prev && (!bus.arvalid || bus.araddr != ar_addr_prev || bus.arlen != ar_len_prev))
        viol_stable <= viol_stable + 1;
      if (aw_wait_prev && (!bus.awvalid || bus.awaddr != aw_addr_prev || bus.awlen != aw_len_prev))
        viol_stable <= viol_stable + 1;
      if (w_wait_prev && (!bus.wvalid || bus.wdata != w_data_prev || bus.wlast != w_last_prev))
        viol_stable <= viol_stable + 1;
      ar_wait_prev <= bus.arvalid && !bus.arready;
      aw_wait_prev <= bus.awvalid && !bus.awready;
      w_wait_prev  <= bus.wvalid && !bus.wready;
      ar_addr_prev <= bus.araddr; ar_len_prev <= bus.arlen;
      aw_addr_prev <= bus.awaddr; aw_len_prev <= bus.awlen;
      w_data_prev  <= bus.wdata;  w_last_prev <= bus.wlast;
      if (bus.wvalid && !wr_active) viol_wearly <= viol_wearly + 1;
      if (bus.arvalid || bus.awvalid || bus.wvalid) valid_cycles <= valid_cycles + 1;

      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0; rd_active <= 1'b1; rd_addr <= bus.araddr; rd_len <= bus.arlen;
        rd_beat <= '0; ar_stall <= stall_pick(); r_stall <= stall_pick();
        if (ar_count < 8) begin
          ar_addr_log[ar_count] <= bus.araddr; ar_len_log[ar_count] <= bus.arlen;
        end
        if (ar_count == 0) ar_attr_log <= {bus.arsize, bus.arburst, bus.arid};
        ar_count <= ar_count + 1;
      end else if (bus.arvalid && !rd_active) begin
        if (ar_stall == 0) bus.arready <= 1'b1;
        else ar_stall <= ar_stall - 1;
      end

      if (rd_active) begin
        if (bus.rvalid && bus.rready) begin
          bus.rvalid <= 1'b0; bus.rlast <= 1'b0;
          if (rd_beat == rd_len) rd_active <= 1'b0;
          rd_beat <= rd_beat + 8'd1; r_stall <= stall_pick();
        end else if (!bus.rvalid) begin
          if (r_stall == 0) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= mem[word_idx(rd_addr, rd_beat)];
            bus.rlast  <= (rd_beat == rd_len);
            bus.rresp  <= (inject_err && ar_count == 1 && rd_beat == 8'd2) ? 2'b10 : 2'b00;
          end else r_stall <= r_stall - 1;
        end
      end

      if (bus.awvalid && bus.awready) begin
        bus.awready <= 1'b0; wr_active <= 1'b1; wr_addr <= bus.awaddr; wr_len <= bus.awlen;
        wr_beat <= '0; aw_stall <= stall_pick(); w_stall <= stall_pick();
        if (aw_count < 8) begin
          aw_addr_log[aw_count] <= bus.awaddr; aw_len_log[aw_count] <= bus.awlen;
        end
        aw_count <= aw_count + 1;
      end else if (bus.awvalid && !wr_active && !b_pend) begin
        if (aw_stall == 0) bus.awready <= 1'b1;
        else aw_stall <= aw_stall - 1;
      end

      if (bus.wvalid && bus.wready) begin
        bus.wready <= 1'b0;
        mem[word_idx(wr_addr, wr_beat)] <= bus.wdata;
        if (bus.wlast != (wr_beat == wr_len) || bus.wstrb != 8'hFF) viol_wbeat <= viol_wbeat + 1;
        w_count <= w_count + 1; wr_beat <= wr_beat + 8'd1; w_stall <= stall_pick();
        if (wr_beat == wr_len) begin
          wr_active <= 1'b0; b_pend <= 1'b1; b_stall <= stall_pick();
        end
      end else if (bus.wvalid && wr_active && !bus.wready) begin
        if (w_stall == 0) bus.wready <= 1'b1;
        else w_stall <= w_stall - 1;
      end

      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; b_pend <= 1'b0; b_count <= b_count + 1;
      end else if (b_pend && !bus.bvalid) begin
        if (b_stall == 0) begin
          bus.bvalid <= 1'b1; bus.bresp <= 2'b00;
        end else b_stall <= b_stall - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else pass_checks++;
  endtask

  task automatic applyReset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 64'h1000 + 64'(i);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge just after the start-accepting edge.
  task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [15:0] n);
    src_addr = s; dst_addr = d; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic modelCopy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++)
      ref_mem[word_idx(d, 8'd0) + i] = ref_mem[word_idx(s, 8'd0) + i];
  endtask

  task automatic waitDone(input string tag);
    int cycles = 0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic compareMem(input string tag);
    int mism = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput({tag, "_mem"}, mism, 0);
  endtask

  initial begin
    $display("[TB] axi4_dma_master directed test");
    applyReset();
    checkOutput("reset_flags", {busy, done, error}, 3'b000);
    checkOutput("reset_bus", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);

    // Single 4-beat burst, with an ignored start while busy.
    applyStimulus(32'h000, 32'h100, 16'd4);
    checkOutput("t1_busy", busy, 1'b1);
    src_addr = 32'h800; dst_addr = 32'h900; num_words = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("t1");
    modelCopy(32'h000, 32'h100, 4);
    checkOutput("t1_ar_count", ar_count, 1);
    checkOutput("t1_arlen", ar_len_log[0], 8'd3);
    checkOutput("t1_ar_attr", ar_attr_log, 13'hD00);
    checkOutput("t1_aw", {aw_addr_log[0], aw_len_log[0]}, {32'h100, 8'd3});
    checkOutput("t1_word3", mem[35], 64'h1003);
    checkOutput("t1_error", error, 1'b0);
    compareMem("t1");

    // 40 words split 16/16/8, overlapping source and destination.
    applyReset();
    applyStimulus(32'h000, 32'h100, 16'd40);
    waitDone("t2");
    modelCopy(32'h000, 32'h100, 40);
    checkOutput("t2_ar_count", ar_count, 3);
    checkOutput("t2_arlens", {ar_len_log[0], ar_len_log[1], ar_len_log[2]}, 24'h0F0F07);
    checkOutput("t2_araddr2", ar_addr_log[2], 32'h100);
    checkOutput("t2_awaddrs", {aw_addr_log[0], aw_addr_log[1], aw_addr_log[2]}, {32'h100, 32'h180, 32'h200});
    checkOutput("t2_last_word", mem[71], 64'h1007);
    compareMem("t2");

    // 4 KB boundary split on the source side.
    applyReset();
    applyStimulus(32'hFF0, 32'h2000, 16'd4);
    waitDone("t3");
    modelCopy(32'hFF0, 32'h2000, 4);
    checkOutput("t3_ar_count", ar_count, 2);
    checkOutput("t3_ar0", {ar_addr_log[0], ar_len_log[0]}, {32'hFF0, 8'd1});
    checkOutput("t3_ar1", {ar_addr_log[1], ar_len_log[1]}, {32'h1000, 8'd1});
    checkOutput("t3_aw1", aw_addr_log[1], 32'h2010);
    checkOutput("t3_dst0", mem[1024], 64'h11FE);
    compareMem("t3");

    // Random stalls on every channel.
    stall_en = 1'b1;
    applyReset();
    applyStimulus(32'h008, 32'h600, 16'd20);
    waitDone("t4");
    modelCopy(32'h008, 32'h600, 20);
    compareMem("t4");
    checkOutput("t4_stable", viol_stable, 0);
    checkOutput("t4_wearly", viol_wearly, 0);
    checkOutput("t4_wbeat", viol_wbeat, 0);
    checkOutput("t4_error", error, 1'b0);
    stall_en = 1'b0;

    // Read error in burst 1: write still completes, no second burst.
    inject_err = 1'b1;
    applyReset();
    applyStimulus(32'h000, 32'h100, 16'd40);
    waitDone("t5");
    checkOutput("t5_ar_count", ar_count, 1);
    checkOutput("t5_w_count", w_count, 16);
    checkOutput("t5_b_count", b_count, 1);
    checkOutput("t5_error", error, 1'b1);
    inject_err = 1'b0;
    applyStimulus(32'h000, 32'h000, 16'd0);
    checkOutput("t5_error_clr", error, 1'b0);
    waitDone("t5b");

    // Zero-length command.
    applyReset();
    applyStimulus(32'h040, 32'h080, 16'd0);
    checkOutput("t6_done_busy", {done, busy}, 2'b10);
    @(negedge clk);
    checkOutput("t6_done_low", done, 1'b0);
    checkOutput("t6_no_valid", valid_cycles, 0);

    // Reset during RD_DATA.
    stall_en = 1'b1;
    applyReset();
    applyStimulus(32'h000, 32'h100, 16'd40);
    for (int c = 0; c < 200 && !bus.rready; c++) @(negedge clk);
    checkOutput("t7_in_rd_data", bus.rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_bus_idle", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);
    checkOutput("t7_flags", {busy, done}, 2'b00);
    rst = 1'b0;
    stall_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 64'h1000 + 64'(i);
    applyStimulus(32'h000, 32'h100, 16'd4);
    waitDone("t7");
    modelCopy(32'h000, 32'h100, 4);
    compareMem("t7");

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end
endmodule
